// File: rtl/alu_issue_ctrl.sv
// Command sequencer for the 16-bit combinational ALU: queues commands, owns the
// A/B/ACC registers, issues one opcode at a time and returns results on a valid/ready port.
module alu_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_op,
    input  logic        cmd_load_a,
    input  logic        cmd_load_b,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [15:0] alu_acc,
    output logic [4:0]  alu_opcode,
    input  logic [31:0] alu_out,
    input  logic        alu_err,
    input  logic        alu_reset,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic [4:0]  res_op
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ALU_LAT - 1);
    localparam logic [4:0]       OP_CLR   = 5'd0;
    localparam logic [4:0]       OP_NOP   = 5'd25;

    typedef struct packed {
        logic [4:0]  op;
        logic        load_a;
        logic        load_b;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    cmd_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;
    cmd_t             head;

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic [4:0]       cur_op;
    logic [15:0]      reg_a;
    logic [15:0]      reg_b;
    logic [15:0]      reg_acc;

    assign push = cmd_valid && cmd_ready;
    assign pop  = (state == IDLE) && (count != '0);
    assign head = fifo_mem[rd_ptr];

    assign alu_a   = reg_a;
    assign alu_b   = reg_b;
    assign alu_acc = reg_acc;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{op: cmd_op, load_a: cmd_load_a, load_b: cmd_load_b,
                                  a: cmd_op == OP_CLR ? 16'd0 : cmd_a, b: cmd_b};
        end
    end

    // Ready is a flop fed from the next count, so a pop never reaches cmd_ready in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_next;
            cmd_ready <= (count_next != FULL_CNT);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            cur_op     <= OP_NOP;
            reg_a      <= '0;
            reg_b      <= '0;
            reg_acc    <= '0;
            alu_opcode <= OP_NOP;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_err    <= 1'b0;
            res_op     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state   <= EXEC;
                        lat_cnt <= LAT_INIT;
                        cur_op  <= head.op;
                        // Opcode 0 clears every operand register regardless of the load flags.
                        if (head.op == OP_CLR) begin
                            reg_a   <= '0;
                            reg_b   <= '0;
                            reg_acc <= '0;
                        end else begin
                            if (head.load_a) begin
                                reg_a <= head.a;
                            end
                            if (head.load_b) begin
                                reg_b <= head.b;
                            end
                        end
                        alu_opcode <= (head.op <= OP_NOP) ? head.op : OP_NOP;
                    end
                end

                EXEC: begin
                    if (lat_cnt == '0) begin
                        state      <= RESP;
                        res_valid  <= 1'b1;
                        res_op     <= cur_op;
                        alu_opcode <= OP_NOP;
                        if (cur_op <= OP_NOP) begin
                            res_data <= alu_out;
                            res_err  <= alu_err;
                            if (alu_reset) begin
                                reg_acc <= '0;
                            end else if (!alu_err && cur_op != OP_NOP) begin
                                reg_acc <= alu_out[15:0];
                            end
                        end else begin
                            res_data <= '0;
                            res_err  <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end

                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a transaction-level model with a command queue
// predicts every output each cycle, plus directed scenarios with hand-computed results.
module tb_alu_issue_ctrl;

    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_op = '0;
    logic        cmd_load_a = 1'b0;
    logic        cmd_load_b = 1'b0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_acc;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_out;
    logic        alu_err;
    logic        alu_reset;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic        res_err;
    logic [4:0]  res_op;

    always #5 clock = ~clock;

    alu_issue_ctrl #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_load_a (cmd_load_a),
        .cmd_load_b (cmd_load_b),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_acc    (alu_acc),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_err    (alu_err),
        .alu_reset  (alu_reset),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .res_op     (res_op)
    );

    typedef struct packed {
        logic [31:0] out;
        logic        err;
        logic        rst;
    } alu_res_t;

    // Behavioural stand-in for the combinational ALU; used both to drive the DUT and inside the model.
    function automatic alu_res_t alu_fn(input logic [4:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [15:0] acc);
        alu_res_t    r;
        logic [31:0] f;
        r.out = '0;
        r.err = 1'b0;
        r.rst = 1'b0;
        case (op)
            5'd0:  r.rst = 1'b1;
            5'd4: begin
                if (a > 16'd12) begin
                    r.err = 1'b1;
                end else begin
                    f = 32'd1;
                    for (int i = 2; i <= 12; i++) begin
                        if (i <= int'(a)) f = f * 32'(i);
                    end
                    r.out = f;
                end
            end
            5'd6:  r.out = 32'(a) + 32'(b);
            5'd9: begin
                if (b == 16'd0) r.err = 1'b1;
                else            r.out = 32'(a / b);
            end
            5'd18: r.out = 32'(acc) + 32'(b);
            5'd19: begin
                if (acc < b) r.err = 1'b1;
                else         r.out = 32'(acc - b);
            end
            5'd25: r.out = '0;
            default: begin
                r.out = {a ^ acc, b} + 32'(op);
                r.err = (op >= 5'd20) && a[0];
            end
        endcase
        return r;
    endfunction

    alu_res_t alu_r;
    assign alu_r     = alu_fn(alu_opcode, alu_a, alu_b, alu_acc);
    assign alu_out   = alu_r.out;
    assign alu_err   = alu_r.err;
    assign alu_reset = alu_r.rst;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  op;
        logic        la;
        logic        lb;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_s;

    cmd_s        q[$];
    logic [15:0] m_a = '0, m_b = '0, m_acc = '0;
    logic [4:0]  m_op = 5'd25;
    int          m_left = 0;
    bit          m_hold = 1'b0;
    bit          m_ready = 1'b0;
    logic [31:0] m_data = '0;
    logic        m_err = 1'b0;
    logic [4:0]  m_rop = '0;

    task automatic model_clear();
        q.delete();
        m_a = '0; m_b = '0; m_acc = '0;
        m_op = 5'd25; m_left = 0; m_hold = 1'b0; m_ready = 1'b0;
        m_data = '0; m_err = 1'b0; m_rop = '0;
    endtask

    task automatic model_step();
        bit       take = cmd_valid && m_ready;
        cmd_s     c;
        alu_res_t r;
        if (m_hold) begin
            if (res_ready) m_hold = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hold = 1'b1;
                m_rop  = m_op;
                if (m_op > 5'd25) begin
                    m_data = '0;
                    m_err  = 1'b1;
                end else begin
                    r      = alu_fn(m_op, m_a, m_b, m_acc);
                    m_data = r.out;
                    m_err  = r.err;
                    if (r.rst)                          m_acc = '0;
                    else if (!r.err && m_op != 5'd25)   m_acc = r.out[15:0];
                end
            end
        end else if (q.size() > 0) begin
            c = q.pop_front();
            if (c.op == 5'd0) begin
                m_a = '0; m_b = '0; m_acc = '0;
            end else begin
                if (c.la) m_a = c.a;
                if (c.lb) m_b = c.b;
            end
            m_op   = c.op;
            m_left = ALU_LAT;
        end
        if (take) q.push_back('{cmd_op, cmd_load_a, cmd_load_b, cmd_a, cmd_b});
        m_ready = (q.size() < DEPTH);
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_clear();
            else       model_step();
        end
    end

    // One compare process: every output against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clock);
            check("cmd_ready",  cmd_ready,  m_ready);
            check("res_valid",  res_valid,  m_hold);
            check("res_data",   res_data,   m_data);
            check("res_err",    res_err,    m_err);
            check("res_op",     res_op,     m_rop);
            check("alu_a",      alu_a,      m_a);
            check("alu_b",      alu_b,      m_b);
            check("alu_acc",    alu_acc,    m_acc);
            check("alu_opcode", alu_opcode, (m_left > 0 && m_op <= 5'd25) ? m_op : 5'd25);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [4:0] op, input logic la, input logic lb,
                        input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        cmd_op = op; cmd_load_a = la; cmd_load_b = lb; cmd_a = a; cmd_b = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("send_accept", cmd_ready, 1'b1);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output logic [31:0] d, output logic e, output logic [4:0] o);
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check("result_arrives", res_valid, 1'b1);
        d = res_data;
        e = res_err;
        o = res_op;
        @(negedge clock);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() > 0 || m_left > 0 || m_hold) && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("drain_idle", res_valid, 1'b0);
    endtask

    initial begin
        int          lat;
        logic [31:0] d;
        logic        e;
        logic [4:0]  o;
        int          accepted;
        int          seen;
        logic [15:0] acc_before;

        repeat (3) @(negedge clock);
        check("ready_in_reset", cmd_ready, 1'b0);
        check("opcode_in_reset", alu_opcode, 5'd25);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", cmd_ready, 1'b1);

        send(5'd6, 1'b1, 1'b1, 16'd3, 16'd2);
        wait_result(lat, d, e, o);
        check("add_latency", 32'(lat), 32'd2);
        check("add_data", d, 32'd5);
        check("add_err", e, 1'b0);
        check("add_acc", alu_acc, 16'd5);

        send(5'd18, 1'b0, 1'b0, 16'd0, 16'd0);
        wait_result(lat, d, e, o);
        check("accb_data", d, 32'd7);
        check("accb_acc", alu_acc, 16'd7);

        send(5'd19, 1'b0, 1'b1, 16'd0, 16'd9);
        wait_result(lat, d, e, o);
        check("sub_err", e, 1'b1);
        check("sub_acc", alu_acc, 16'd7);

        send(5'd4, 1'b1, 1'b0, 16'd12, 16'd0);
        wait_result(lat, d, e, o);
        check("fact_data", d, 32'h1C8C_FC00);
        check("fact_err", e, 1'b0);
        check("fact_acc", alu_acc, 16'hFC00);

        send(5'd9, 1'b0, 1'b1, 16'd0, 16'd0);
        wait_result(lat, d, e, o);
        check("div0_err", e, 1'b1);
        check("div0_acc", alu_acc, 16'hFC00);

        res_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_op = 5'(i + 1); cmd_load_a = 1'b1; cmd_load_b = 1'b1;
            cmd_a = 16'(i + 2); cmd_b = 16'(3 * i + 1);
            cmd_valid = 1'b1;
            if (cmd_ready) accepted++;
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd5);
        check("bp_ready_low", cmd_ready, 1'b0);
        res_ready = 1'b1;
        @(negedge clock);
        check("bp_ready_still_low", cmd_ready, 1'b0);
        @(negedge clock);
        check("bp_ready_after_pop", cmd_ready, 1'b1);
        drain();

        acc_before = m_acc;
        send(5'd27, 1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clock);
        check("illegal_opcode_held", alu_opcode, 5'd25);
        wait_result(lat, d, e, o);
        check("illegal_data", d, 32'd0);
        check("illegal_err", e, 1'b1);
        check("illegal_op", o, 5'd27);
        check("illegal_acc", alu_acc, acc_before);

        send(5'd0, 1'b1, 1'b1, 16'h1234, 16'h5678);
        wait_result(lat, d, e, o);
        check("clr_a", alu_a, 16'd0);
        check("clr_b", alu_b, 16'd0);
        check("clr_acc", alu_acc, 16'd0);
        check("clr_op", o, 5'd0);

        for (int i = 0; i < 3; i++) begin
            cmd_op = 5'd6; cmd_load_a = 1'b1; cmd_load_b = 1'b1;
            cmd_a = 16'(i + 1); cmd_b = 16'd7;
            cmd_valid = 1'b1;
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        seen = 0;
        while (alu_opcode != 5'd6 && seen < 20) begin
            @(negedge clock);
            seen++;
        end
        check("reached_exec", alu_opcode, 5'd6);
        #2 reset = 1'b1;
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_opcode", alu_opcode, 5'd25);
        check("rst_a", alu_a, 16'd0);
        check("rst_acc", alu_acc, 16'd0);
        check("rst_res_data", res_data, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (res_valid) seen++;
        end
        check("no_result_after_reset", 32'(seen), 32'd0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            cmd_valid  = ($urandom_range(0, 99) < 60);
            cmd_op     = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
            cmd_load_a = 1'($urandom_range(0, 1));
            cmd_load_b = 1'($urandom_range(0, 1));
            cmd_a      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            cmd_b      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            res_ready  = ($urandom_range(0, 99) < 50);
            if (cyc == 1500) begin
                #2 reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream sequencer for the 16-bit ALU. Owns the A, B and accumulator registers, which it holds itself rather than leaving them as loose muxes and DFFs in the bench.
- Buffers incoming commands (opcode plus optional operand loads) in a small FIFO and issues them one at a time to the combinational ALU.
- Waits a fixed settle time, captures the 32-bit result and error flag, updates the accumulator, and presents the result on a valid/ready output port.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, at least 2).
- ALU_LAT, 1, cycles the opcode/operands are held stable before the ALU output is sampled (at least 1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full, registered-state only.
- cmd_op  in  5  ALU opcode, 0..25 legal.
- cmd_load_a  in  1  load A from cmd_a before issuing.
- cmd_load_b  in  1  load B from cmd_b before issuing.
- cmd_a  in  16  operand A value.
- cmd_b  in  16  operand B value.
- alu_a  out  16  A register to ALU.
- alu_b  out  16  B register to ALU.
- alu_acc  out  16  accumulator register to ALU.
- alu_opcode  out  5  opcode to ALU; 25 (no-op) when not executing.
- alu_out  in  32  ALU result.
- alu_err  in  1  ALU error flag.
- alu_reset  in  1  ALU clear indication (asserted for opcode 0).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  32  captured result.
- res_err  out  1  captured error / illegal-op flag.
- res_op  out  5  opcode that produced res_data.

Behaviour:
- **Reset values.** While reset is high, all of these are 0: A, B, ACC, FIFO pointers and count, res_valid, res_data, res_err, res_op. alu_opcode is 25 and the FSM is in IDLE. cmd_ready rises on the first clock edge after reset is released.
- **FIFO.** A push occurs when cmd_valid && cmd_ready. Pointers wrap modulo DEPTH.
  - A push while full is impossible, because cmd_ready is low.
  - A push and a pop in the same cycle leave the count unchanged.
  - A pop that frees a slot raises cmd_ready only on the next cycle; there is no combinational path from pop to ready.
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE.** If the FIFO is non-empty, pop the head entry and move to EXEC, with the counter set to ALU_LAT-1. The popped entry's loads are applied on the same edge:
  - cmd_op==0 sets A, B and ACC to 0. This overrides the load flags.
  - Otherwise A<=cmd_a if load_a, and B<=cmd_b if load_b.
  - A command pushed into an empty FIFO while IDLE is popped on the following edge.
- **EXEC.** alu_opcode is driven with the entry's opcode, and alu_a, alu_b and alu_acc show the updated registers. The counter decrements each cycle. On the edge where the counter reaches 0, capture and move to RESP:
  - Legal op: res_data<=alu_out, res_err<=alu_err, res_op<=op.
  - ACC update:
    - alu_reset=1: ACC<=0.
    - Else if alu_err=0 and op!=25: ACC<=alu_out[15:0]. The upper 16 bits are dropped.
    - Else (error or no-op): ACC unchanged.
  - Illegal op (26..31): alu_opcode stays 25, res_data<=0, res_err<=1, and ACC, A and B are unchanged apart from the loads already applied.
- **RESP.** res_valid=1, and res_data, res_err and res_op are stable. When res_ready is high at a clock edge, res_valid falls after that edge and the FSM returns to IDLE. The next command is popped no earlier than the edge after that, so there is no back-to-back issue.
- **Latency.** A command pushed at edge N into an empty FIFO with the FSM in IDLE gives res_valid high after edge N+1+ALU_LAT. For ALU_LAT=1 that is N+2.
- **FIFO filling.** The FIFO keeps filling while the FSM waits in RESP, so backpressure propagates to cmd_ready only once DEPTH entries are stored.
- **Reset mid-operation.** Asserting reset at any point aborts the operation immediately. Queued commands and the pending result are discarded, and no partial ACC update occurs.
- **ALU interface.** The ALU is combinational; this block registers every alu_* output.

Test Plan:
- Release reset; push {op=6, load_a, load_b, a=3, b=2}. Expect res_data=5, res_err=0 and ACC=5, with res_valid 2 cycles after the push.
- Then push {op=18}. Expect res_data=7 and ACC=7. Then push {op=19, load_b, b=9}. Expect res_err=1 (ALU flags ACC<B), with ACC still 7.
- Push {op=4, load_a, a=12}. Expect res_data=479001600 (0x1C8CFC00), res_err=0 and ACC=0xFC00. Then push {op=9, load_b, b=0}. Expect res_err=1 and ACC unchanged at 0xFC00.
- Hold res_ready=0 and push 6 commands back-to-back. Expect exactly 5 accepted (1 executing plus DEPTH=4 queued) and cmd_ready low. Then release res_ready: results emerge in order, and cmd_ready rises one cycle after the first pop.
- Push {op=27}. Expect res_err=1, res_data=0, ACC unchanged, and alu_opcode held at 25 throughout. Then push {op=0}. Expect A, B and ACC all 0 and res_op=0.
- Queue 3 commands and assert reset asynchronously in the middle of EXEC. Expect all outputs at their reset values immediately, the FIFO empty, and no result issued after reset is released.
